// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word width, reset/NOP constants and the IF/ID record.
// Reused by the fetch, decode and hazard blocks.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC priority: branch, then jump, then hold, then PC+4.
// A branch resolved in EX is older than a jump in ID, so it wins when both fire.
module pc_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pcsrc,
    input  logic        i_jump,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic        i_hold,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc4;

    assign w_pc4 = pc_plus4(r_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_pcsrc) begin
            r_pc <= i_branch_target;
        end else if (i_jump) begin
            r_pc <= i_jump_target;
        end else if (!i_hold) begin
            r_pc <= w_pc4;
        end
    end

    assign o_pc  = r_pc;
    assign o_pc4 = w_pc4;

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC, instruction-memory address, IF/ID register and a
// saturating count of flushed fetch cycles.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic             if_flush,
    input  logic             stall,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0]      w_pc;
    logic [31:0]      w_pc4;
    logic             w_hold;
    if_id_t           r_if_id;
    logic [CNT_W-1:0] r_flush_count;

    assign w_hold = stall | ~imem_ready;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pcsrc        (pcsrc),
        .i_jump         (jump),
        .i_branch_target(branch_target),
        .i_jump_target  (jump_target),
        .i_hold         (w_hold),
        .o_pc           (w_pc),
        .o_pc4          (w_pc4)
    );

    // Flush beats stall; a memory miss bubbles but keeps pc4 for debug continuity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= 32'd0;
            r_if_id.valid <= 1'b0;
        end else if (if_flush) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= 32'd0;
            r_if_id.valid <= 1'b0;
        end else if (stall) begin
            r_if_id <= r_if_id;
        end else if (!imem_ready) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.valid <= 1'b0;
        end else begin
            r_if_id.instr <= imem_rdata;
            r_if_id.pc4   <= w_pc4;
            r_if_id.valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_count <= '0;
        end else if (if_flush && (r_flush_count != {CNT_W{1'b1}})) begin
            r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign imem_addr   = w_pc;
    assign if_id_instr = r_if_id.instr;
    assign if_id_pc4   = r_if_id.pc4;
    assign if_id_valid = r_if_id.valid;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage: reference model plus hand-computed checkpoints.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] jump_target = 32'd0;
    logic        if_flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h2008_0005;
    logic        imem_ready = 1'b1;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [15:0] flush_count;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcsrc        (pcsrc),
        .jump         (jump),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .if_flush     (if_flush),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .flush_count  (flush_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state updated from the written fetch rules.
    longint m_pc = 0;
    longint m_instr = 0;
    longint m_pc4 = 0;
    int     m_valid = 0;
    int     m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        longint n_pc;
        longint seq_pc4;
        if (!rst_n) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else begin
            seq_pc4 = (m_pc + 4) % 64'h1_0000_0000;
            if (pcsrc)                    n_pc = branch_target;
            else if (jump)                n_pc = jump_target;
            else if (stall || !imem_ready) n_pc = m_pc;
            else                          n_pc = seq_pc4;
            if (if_flush) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (stall) begin
                // IF/ID unchanged
            end else if (!imem_ready) begin
                m_instr = 0; m_valid = 0;
            end else begin
                m_instr = imem_rdata; m_pc4 = seq_pc4; m_valid = 1;
            end
            m_pc = n_pc;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_addr",  imem_addr,           32'(m_pc));
            check("model_instr", if_id_instr,         32'(m_instr));
            check("model_pc4",   if_id_pc4,           32'(m_pc4));
            check("model_valid", {31'd0, if_id_valid}, 32'(m_valid));
            check("model_count", {16'd0, flush_count}, 32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_ctl();
        pcsrc = 0; jump = 0; if_flush = 0; stall = 0; imem_ready = 1;
    endtask

    initial begin
        step(2);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4",   if_id_pc4, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'h0);
        check("rst_count", {16'd0, flush_count}, 32'h0);
        cmp_en = 1'b1;
        rst_n = 1'b1;

        // free run
        step(1);
        check("run_addr4",  imem_addr, 32'h4);
        check("run_instr",  if_id_instr, 32'h2008_0005);
        check("run_pc4",    if_id_pc4, 32'h4);
        check("run_valid",  {31'd0, if_id_valid}, 32'h1);
        step(1);
        check("run_addr8",  imem_addr, 32'h8);
        step(2);
        check("run_addr10", imem_addr, 32'h10);

        // branch beats jump, with flush
        pcsrc = 1; jump = 1; branch_target = 32'h40; jump_target = 32'h80; if_flush = 1;
        step(1);
        check("br_addr",  imem_addr, 32'h40);
        check("br_instr", if_id_instr, 32'h0);
        check("br_valid", {31'd0, if_id_valid}, 32'h0);
        check("br_count", {16'd0, flush_count}, 32'h1);
        clear_ctl();

        // stall at 0x20
        imem_rdata = 32'h8C08_0000; jump = 1; jump_target = 32'h20;
        step(1);
        check("j_addr", imem_addr, 32'h20);
        check("j_pc4",  if_id_pc4, 32'h44);
        jump = 0; stall = 1;
        step(1);
        check("st1_addr",  imem_addr, 32'h20);
        check("st1_instr", if_id_instr, 32'h8C08_0000);
        step(1);
        check("st2_addr", imem_addr, 32'h20);
        check("st2_pc4",  if_id_pc4, 32'h44);
        stall = 0; imem_rdata = 32'h0109_5020;
        step(1);
        check("st_resume_addr", imem_addr, 32'h24);
        check("st_resume_pc4",  if_id_pc4, 32'h24);
        stall = 1;
        step(1);
        check("st_hold_pc4", if_id_pc4, 32'h24);
        if_flush = 1;
        step(1);
        check("stfl_addr",  imem_addr, 32'h24);
        check("stfl_valid", {31'd0, if_id_valid}, 32'h0);
        check("stfl_pc4",   if_id_pc4, 32'h0);
        check("stfl_count", {16'd0, flush_count}, 32'h2);
        clear_ctl();
        step(1);
        check("post_addr", imem_addr, 32'h28);
        check("post_pc4",  if_id_pc4, 32'h28);

        // redirect during stall
        stall = 1; pcsrc = 1; branch_target = 32'h100;
        step(1);
        check("rs_addr", imem_addr, 32'h100);
        check("rs_pc4",  if_id_pc4, 32'h28);
        clear_ctl();

        // memory not ready for 3 cycles
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("nr_addr",  imem_addr, 32'h100);
            check("nr_valid", {31'd0, if_id_valid}, 32'h0);
            check("nr_pc4",   if_id_pc4, 32'h28);
        end
        imem_ready = 1;
        step(1);
        check("nr_done_addr",  imem_addr, 32'h104);
        check("nr_done_valid", {31'd0, if_id_valid}, 32'h1);
        imem_ready = 0; jump = 1; jump_target = 32'h200;
        step(1);
        check("rnr_addr",  imem_addr, 32'h200);
        check("rnr_valid", {31'd0, if_id_valid}, 32'h0);
        check("rnr_pc4",   if_id_pc4, 32'h104);

        // PC wrap
        imem_ready = 1; jump_target = 32'hFFFF_FFFC;
        step(1);
        check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        jump = 0;
        step(1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4",  if_id_pc4, 32'h0);

        // flush counter saturation
        if_flush = 1;
        step(65541);
        check("sat_count", {16'd0, flush_count}, 32'hFFFF);
        step(2);
        check("sat_hold", {16'd0, flush_count}, 32'hFFFF);

        // async reset mid-cycle during a stall
        if_flush = 0; stall = 1;
        step(1);
        rst_n = 0;
        #1;
        check("arst_addr",  imem_addr, 32'h0);
        check("arst_instr", if_id_instr, 32'h0);
        check("arst_pc4",   if_id_pc4, 32'h0);
        check("arst_valid", {31'd0, if_id_valid}, 32'h0);
        check("arst_count", {16'd0, flush_count}, 32'h0);
        clear_ctl();
        step(2);
        rst_n = 1;
        step(1);
        check("rerun_addr", imem_addr, 32'h4);
        step(1);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline: holds the PC, drives the instruction-memory address and owns the IF/ID pipeline register.
- Consumes the redirect controls (pcsrc, jump, targets), the branch controller's IF flush, and the hazard unit's stall.
- Produces the IF/ID instruction, PC+4 and a valid bit for the decode stage.
- Keeps a saturating count of flushed fetch cycles for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a bubble (sll $0,$0,0).
- CNT_W, 16, width of the flush counter.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pcsrc  in  1  taken branch resolved in EX; redirect to branch_target.
- jump  in  1  jump decoded in ID; redirect to jump_target.
- branch_target  in  32  branch destination address.
- jump_target  in  32  jump destination address.
- if_flush  in  1  squash the instruction currently in fetch, from the branch controller.
- stall  in  1  load-use stall from the hazard unit; freeze PC and IF/ID.
- imem_addr  out  32  instruction-memory address; equals PC, combinational.
- imem_rdata  in  32  fetched instruction word.
- imem_ready  in  1  imem_rdata is valid this cycle.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- flush_count  out  CNT_W  saturating count of cycles with if_flush=1.

Behaviour:
- Reset (rst_n=0, async): PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, flush_count=0. All outputs take reset values immediately, including mid-fetch.
- Decode latency: one cycle from imem_ready to the IF/ID outputs.
- redirect = pcsrc | jump.
- PC priority, per cycle at posedge clk, highest first:
  - pcsrc: PC <= branch_target. pcsrc beats jump when both are high, because the branch in EX is older.
  - jump: PC <= jump_target.
  - stall or !imem_ready: PC holds.
  - otherwise: PC <= PC+4. Arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID priority, highest first:
  - if_flush: instr=NOP_INSTR, pc4=0, valid=0. Flush beats stall.
  - stall: hold all three fields.
  - !imem_ready: bubble. instr=NOP_INSTR, valid=0, pc4 holds.
  - otherwise: instr=imem_rdata, pc4=PC+4, valid=1.
- Redirect during stall: the redirect wins and PC takes the target. IF/ID holds unless if_flush is also set.
- if_flush without redirect: IF/ID bubbles; PC follows the normal rules above.
- Redirect with imem_ready=0: PC takes the target; IF/ID bubbles.
- flush_count: increments by 1 on each clock with if_flush=1. It saturates at all-ones and does not wrap. Only reset clears it.
- PC[1:0] is always 0. Targets are used as given; the upstream blocks guarantee word alignment.

Decomposition:
- Shared package (pipe_pkg): NOP_INSTR, RESET_PC, the 32-bit word width and an IF/ID record {instr, pc4, valid}. ID and the hazard unit reuse these.
- One sub-module, pc_reg: the PC register with next-PC priority mux and PC+4 adder.
- The IF/ID register and flush counter stay in if_stage.

Test Plan:
- Reset then free run, imem_ready=1, imem_rdata=0x2008_0005 -> PC goes 0,4,8; cycle 2 shows if_id_instr=0x2008_0005, if_id_pc4=4, if_id_valid=1.
- Branch with PC=0x10, pcsrc=1, jump=1, branch_target=0x40, jump_target=0x80, if_flush=1 -> next PC=0x40, IF/ID=NOP with valid=0, flush_count +1.
- stall=1 for 2 cycles at PC=0x20 -> PC stays 0x20 and IF/ID is unchanged for both cycles; resumes 0x24 after stall drops. Repeat with if_flush=1 on cycle 2 -> IF/ID bubble despite the stall.
- imem_ready=0 for 3 cycles -> PC holds and if_id_valid=0 for 3 cycles; then a normal fetch with valid=1.
- Hold if_flush=1 for 2^16+5 cycles -> flush_count ends at 0xFFFF; PC=0xFFFF_FFFC advancing -> 0x0.
- Assert rst_n=0 mid-cycle during a stall -> outputs go to reset values before the next clock edge.
